// File: rtl/pc_unit_if.sv
// Program-counter control bus: load enable, source select, targets, and PC readback.
interface pc_unit_if;
    logic        LD;
    logic [1:0]  PCSEL;
    logic [15:0] OFFSET;
    logic [15:0] DIRECT;
    logic [15:0] PC_OUT;

    // Sequencer side: drives the next-PC controls and observes the PC.
    modport master (
        output LD,
        output PCSEL,
        output OFFSET,
        output DIRECT,
        input  PC_OUT
    );

    // PC side: consumes the controls and presents the current PC.
    modport slave (
        input  LD,
        input  PCSEL,
        input  OFFSET,
        input  DIRECT,
        output PC_OUT
    );
endinterface

// File: rtl/pc_unit.sv
// 16-bit program counter with increment, offset, direct and hold next-PC sources.

// Incrementer: D_IN + 1, wrapping modulo 2^16, no carry out.
module inc1 (
    input  logic [15:0] D_IN,
    output logic [15:0] D_OUT
);
    assign D_OUT = D_IN + 16'd1;
endmodule

// 4-to-1 16-bit multiplexer, every select code decoded.
module mux16_4to1 (
    input  logic [1:0]  SEL,
    input  logic [15:0] D_IN0,
    input  logic [15:0] D_IN1,
    input  logic [15:0] D_IN2,
    input  logic [15:0] D_IN3,
    output logic [15:0] D_OUT
);
    // Route the selected input to the output.
    always_comb begin
        D_OUT = D_IN0;
        case (SEL)
            2'b00:   D_OUT = D_IN0;
            2'b01:   D_OUT = D_IN1;
            2'b10:   D_OUT = D_IN2;
            2'b11:   D_OUT = D_IN3;
            default: D_OUT = D_IN0;
        endcase
    end
endmodule

// PC register fed by the next-PC multiplexer.
module pc_unit (
    input  logic     CLK,
    input  logic     RESET,
    pc_unit_if.slave bus
);
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [15:0] pc_next;

    inc1 u_inc1 (
        .D_IN  (pc),
        .D_OUT (pc_inc)
    );

    mux16_4to1 u_mux (
        .SEL   (bus.PCSEL),
        .D_IN0 (pc_inc),
        .D_IN1 (bus.OFFSET),
        .D_IN2 (bus.DIRECT),
        .D_IN3 (pc),
        .D_OUT (pc_next)
    );

    // Synchronous reset to zero; otherwise load the selected source when LD is set.
    always_ff @(posedge CLK) begin
        if (RESET)
            pc <= '0;
        else if (bus.LD)
            pc <= pc_next;
    end

    assign bus.PC_OUT = pc;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit with a behavioural next-PC model.
module tb_pc_unit;
    logic CLK;
    logic RESET;

    pc_unit_if bus ();

    pc_unit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    logic [15:0] inc_in, inc_out;
    inc1 u_inc (
        .D_IN  (inc_in),
        .D_OUT (inc_out)
    );

    logic [1:0]  m_sel;
    logic [15:0] m_in0, m_in1, m_in2, m_in3, m_out;
    mux16_4to1 u_mux (
        .SEL   (m_sel),
        .D_IN0 (m_in0),
        .D_IN1 (m_in1),
        .D_IN2 (m_in2),
        .D_IN3 (m_in3),
        .D_OUT (m_out)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned exp_pc = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic rst, input logic ld, input logic [1:0] sel,
                         input logic [15:0] off, input logic [15:0] dir);
        RESET      = rst;
        bus.LD     = ld;
        bus.PCSEL  = sel;
        bus.OFFSET = off;
        bus.DIRECT = dir;
    endtask

    // One clock edge: advance the model from the applied inputs, then compare.
    task automatic tick(input string tag);
        @(posedge CLK);
        if (RESET)
            exp_pc = 0;
        else if (bus.LD) begin
            if (bus.PCSEL == 2'd0)      exp_pc = (exp_pc + 1) % 65536;
            else if (bus.PCSEL == 2'd1) exp_pc = int'(bus.OFFSET);
            else if (bus.PCSEL == 2'd2) exp_pc = int'(bus.DIRECT);
        end
        #1;
        check(tag, bus.PC_OUT, exp_pc[15:0]);
    endtask

    initial begin
        logic [15:0] vals [4];
        drive(1'b0, 1'b0, 2'd0, '0, '0);
        inc_in = '0;
        m_sel = '0; m_in0 = 16'h1111; m_in1 = 16'h2222; m_in2 = 16'h3333; m_in3 = 16'h4444;

        // Standalone incrementer corners
        #1; check("inc1_0000", inc_out, 16'h0001);
        inc_in = 16'h7FFF; #1; check("inc1_7fff", inc_out, 16'h8000);
        inc_in = 16'hFFFF; #1; check("inc1_ffff", inc_out, 16'h0000);

        // Standalone mux: each select returns its own input
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
        for (int s = 0; s < 4; s++) begin
            m_sel = 2'(s);
            #1; check($sformatf("mux_sel%0d", s), m_out, vals[s]);
        end

        // Reset with LD low, then three increments
        @(posedge CLK); #1;
        drive(1'b1, 1'b0, 2'd2, 16'hAAAA, 16'h5555); tick("reset");
        drive(1'b0, 1'b1, 2'd0, '0, '0);
        tick("inc_1"); tick("inc_2"); tick("inc_3");

        // Offset and direct loads
        drive(1'b0, 1'b1, 2'd1, 16'h001F, 16'h0000); tick("offset_load");
        drive(1'b0, 1'b1, 2'd2, 16'h0000, 16'h007B); tick("direct_load");

        // Hold via select 11, then increment
        drive(1'b0, 1'b1, 2'd3, 16'hDEAD, 16'hBEEF); tick("hold_1"); tick("hold_2");
        drive(1'b0, 1'b1, 2'd0, 16'hDEAD, 16'hBEEF); tick("inc_after_hold");

        // LD=0 holds across every select code
        drive(1'b0, 1'b1, 2'd2, 16'h0000, 16'h1234); tick("load_1234");
        for (int s = 0; s < 4; s++) begin
            drive(1'b0, 1'b0, 2'(s), 16'(16'h0100 * s + 7), 16'(16'h0F00 - s));
            tick($sformatf("ld0_sel%0d", s));
        end

        // Mid-cycle input and reset changes must not disturb PC_OUT
        #2;
        drive(1'b1, 1'b1, 2'd1, 16'h9999, 16'h8888);
        #1; check("midcycle_reset", bus.PC_OUT, 16'h1234);
        drive(1'b0, 1'b0, 2'd0, '0, '0);

        // Wrap from 0xFFFF through zero
        drive(1'b0, 1'b1, 2'd2, 16'h0000, 16'hFFFF); tick("load_ffff");
        drive(1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000); tick("wrap_0000"); tick("wrap_0001");

        // Reset mid-sequence then resume
        drive(1'b1, 1'b1, 2'd1, 16'h4321, 16'h0000); tick("reset_mid");
        drive(1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000); tick("after_reset");

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [15:0] off, dir;
            off = 16'($urandom);
            dir = ($urandom_range(0, 7) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
            drive($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)), off, dir);
            tick("random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
